// File: rtl/efx_hbram_pkg.sv
// efx_hbram_pkg: shared state encodings, width ratio helper and watchdog default
package efx_hbram_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TRIG  = 3'd2,
    WBUSY = 3'd3,
    WIDLE = 3'd4,
    DONE  = 3'd5
  } state_t;
  localparam int DEF_TIMEOUT_CYC = 4096;
  function automatic int dratio(input int user_dbw, input int ram_dbw);
    return (user_dbw / (ram_dbw * 2)) < 1 ? 1 : user_dbw / (ram_dbw * 2);
  endfunction
endpackage

// File: rtl/efx_hyper_ram_native_arb_if.sv
// efx_hyper_ram_native_arb_if: HyperRAM native controller port
interface efx_hyper_ram_native_arb_if #(parameter int USER_DBW = 128);
  logic ram_en;
  logic ram_rdwr;
  logic [31:0] ram_address;
  logic [10:0] burst_len;
  logic wr_en;
  logic [USER_DBW-1:0] wr_data;
  logic wr_buf_ready;
  logic [USER_DBW-1:0] rd_data;
  logic rd_valid;
  logic ctrl_idle;
  modport master (
    output ram_en, ram_rdwr, ram_address, burst_len, wr_en, wr_data,
    input  wr_buf_ready, rd_data, rd_valid, ctrl_idle
  );
  modport slave (
    input  ram_en, ram_rdwr, ram_address, burst_len, wr_en, wr_data,
    output wr_buf_ready, rd_data, rd_valid, ctrl_idle
  );
endinterface

// File: rtl/efx_rr_arb2.sv
// efx_rr_arb2: two-way round-robin pick with pointer register
module efx_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt,
  output logic       win
);
  logic ptr;
  assign win = req[ptr] ? ptr : ~ptr;
  assign gnt = en && |req;
  // pointer moves past the winner on every grant
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (gnt) ptr <= ~win;
endmodule

// File: rtl/efx_hyper_ram_native_arb.sv
// efx_hyper_ram_native_arb: two-master arbiter and transaction sequencer for the HyperRAM native port
module efx_hyper_ram_native_arb
  import efx_hbram_pkg::*;
#(
  parameter int USER_DBW    = 128,
  parameter int RAM_DBW     = 32,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cal_done,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_rdwr,
  input  logic [63:0]           req_addr,
  input  logic [21:0]           req_len,
  output logic [1:0]            req_ack,
  output logic [1:0]            req_done,
  output logic [1:0]            req_err,
  output logic [1:0]            wr_pull,
  input  logic [2*USER_DBW-1:0] wr_data_in,
  output logic [USER_DBW-1:0]   rd_data_out,
  output logic [1:0]            rd_valid_out,
  output logic                  owner,
  output logic                  busy,
  efx_hyper_ram_native_arb_if.master ram
);
  localparam int SH = $clog2(dratio(USER_DBW, RAM_DBW));
  state_t state, state_n;
  logic rdwr_q, gnt, win, tmo, wait_st;
  logic [10:0] beats, wcnt, rcnt, len_w, beats_w;
  logic [31:0] wdog;
  efx_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state == IDLE && cal_done),
    .req (req_valid),
    .gnt (gnt),
    .win (win)
  );
  assign len_w          = win ? req_len[21:11] : req_len[10:0];
  assign beats_w        = (len_w >> SH) == 11'd0 ? 11'd1 : len_w >> SH;
  assign wait_st        = state inside {LOAD, WBUSY, WIDLE};
  assign tmo            = TIMEOUT_CYC != 0 && wait_st && wdog == 32'(TIMEOUT_CYC);
  assign ram.wr_en      = state == LOAD && wcnt != beats && ram.wr_buf_ready;
  assign ram.wr_data    = owner ? wr_data_in[2*USER_DBW-1:USER_DBW] : wr_data_in[USER_DBW-1:0];
  assign ram.ram_en     = state == TRIG;
  assign ram.ram_rdwr   = rdwr_q;
  assign wr_pull        = ram.wr_en ? {owner, ~owner} : 2'b00;
  assign req_done       = state == DONE ? {owner, ~owner} : 2'b00;
  assign req_err        = tmo ? {owner, ~owner} : 2'b00;
  assign rd_data_out    = ram.rd_data;
  assign rd_valid_out   = ram.rd_valid ? {owner, ~owner} : 2'b00;
  assign busy           = state != IDLE;
  // next-state: one transaction at a time, watchdog abort overrides everything
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt) state_n = req_rdwr[win] ? TRIG : LOAD;
      LOAD:    if (ram.wr_en && wcnt == beats - 11'd1) state_n = TRIG;
      TRIG:    state_n = WBUSY;
      WBUSY:   if (!ram.ctrl_idle) state_n = WIDLE;
      WIDLE:   if (ram.ctrl_idle && (!rdwr_q || rcnt == beats)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = IDLE;
  end
  // state, request latch, beat counters and watchdog
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      rdwr_q          <= 1'b1;
      ram.ram_address <= '0;
      ram.burst_len   <= '0;
      beats           <= '0;
      wcnt            <= '0;
      rcnt            <= '0;
      wdog            <= '0;
      req_ack         <= 2'b00;
    end else begin
      state   <= state_n;
      wdog    <= state_n != state ? '0 : (wait_st && TIMEOUT_CYC != 0) ? wdog + 32'd1 : wdog;
      req_ack <= gnt ? {win, ~win} : 2'b00;
      if (gnt) begin
        owner           <= win;
        rdwr_q          <= req_rdwr[win];
        ram.ram_address <= win ? req_addr[63:32] : req_addr[31:0];
        ram.burst_len   <= len_w;
        beats           <= beats_w;
        wcnt            <= '0;
        rcnt            <= '0;
      end else begin
        if (ram.wr_en) wcnt <= wcnt + 11'd1;
        if (ram.rd_valid && state != IDLE && rdwr_q && rcnt != beats) rcnt <= rcnt + 11'd1;
      end
    end
endmodule

// File: tb/tb_efx_hyper_ram_native_arb.sv
// tb_efx_hyper_ram_native_arb: directed scenarios for the HyperRAM native-port arbiter
module tb_efx_hyper_ram_native_arb;
  localparam int UDW = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cal_done = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_valid2 = 2'b00;
  logic [1:0] req_rdwr = 2'b00;
  logic [63:0] req_addr = '0;
  logic [21:0] req_len = '0;
  logic [2*UDW-1:0] wr_data_in = '0;
  logic [1:0] req_ack, req_done, req_err, wr_pull, rd_valid_out;
  logic [UDW-1:0] rd_data_out;
  logic owner, busy;
  logic [1:0] req_ack2, req_done2, req_err2, wr_pull2, rd_valid_out2;
  logic [UDW-1:0] rd_data_out2;
  logic owner2, busy2;
  int checks = 0;
  int failures = 0;

  efx_hyper_ram_native_arb_if #(.USER_DBW(UDW)) ram ();
  efx_hyper_ram_native_arb_if #(.USER_DBW(UDW)) ram2 ();

  always #5 clk = ~clk;

  efx_hyper_ram_native_arb #(.USER_DBW(UDW), .RAM_DBW(32), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .rst(rst), .cal_done(cal_done), .req_valid(req_valid), .req_rdwr(req_rdwr),
    .req_addr(req_addr), .req_len(req_len), .req_ack(req_ack), .req_done(req_done),
    .req_err(req_err), .wr_pull(wr_pull), .wr_data_in(wr_data_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .owner(owner), .busy(busy), .ram(ram)
  );

  efx_hyper_ram_native_arb #(.USER_DBW(UDW), .RAM_DBW(32), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .rst(rst), .cal_done(cal_done), .req_valid(req_valid2), .req_rdwr(req_rdwr),
    .req_addr(req_addr), .req_len(req_len), .req_ack(req_ack2), .req_done(req_done2),
    .req_err(req_err2), .wr_pull(wr_pull2), .wr_data_in(wr_data_in), .rd_data_out(rd_data_out2),
    .rd_valid_out(rd_valid_out2), .owner(owner2), .busy(busy2), .ram(ram2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int who);
    int n = 0;
    while (req_ack == 2'b00 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (req_ack !== (2'b01 << who)) begin
      failures++;
      $display("FAIL ack_req%0d: got %b want %b", who, req_ack, 2'b01 << who);
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if ({busy, ram.ram_en, ram.wr_en, owner, req_ack, req_done, req_err} !== 9'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 0", {busy, ram.ram_en, ram.wr_en, owner, req_ack, req_done, req_err});
    end
    checks++;
    if (ram.ram_rdwr !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdwr: got %b want 1", ram.ram_rdwr);
    end
    checks++;
    if (ram.ram_address !== 32'd0 || ram.burst_len !== 11'd0) begin
      failures++;
      $display("FAIL reset_addr_len: got %h/%0d want 0/0", ram.ram_address, ram.burst_len);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    int beats = 0;
    int pull_bad = 0;
    int data_bad = 0;
    int d0 = 0;
    int d1 = 0;
    logic seen_en = 1'b0;
    wr_data_in = {128'hCAFE_0000_0000_0000_0000_0000_0000_0001, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978};
    req_rdwr = 2'b00;
    req_addr = {32'h0, 32'h0000_1000};
    req_len = {11'd0, 11'd128};
    req_valid = 2'b01;
    wait_ack(0);
    req_valid = 2'b00;
    for (int n = 0; n < 200 && !seen_en; n++) begin
      if (ram.ram_en) seen_en = 1'b1;
      else begin
        if (ram.wr_en) begin
          beats++;
          if (wr_pull !== 2'b01) pull_bad++;
          if (ram.wr_data !== 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978) data_bad++;
        end
        tick;
      end
    end
    checks++;
    if (beats != 64 || !seen_en) begin
      failures++;
      $display("FAIL write_beats: got %0d (ram_en %b) want 64 (ram_en 1)", beats, seen_en);
    end
    checks++;
    if (pull_bad != 0 || data_bad != 0) begin
      failures++;
      $display("FAIL write_pull_data: got pull_bad=%0d data_bad=%0d want 0/0", pull_bad, data_bad);
    end
    checks++;
    if (ram.ram_rdwr !== 1'b0 || ram.ram_address !== 32'h1000 || ram.burst_len !== 11'd128) begin
      failures++;
      $display("FAIL write_trig: got rdwr=%b addr=%h len=%0d want 0/1000/128", ram.ram_rdwr, ram.ram_address, ram.burst_len);
    end
    tick;
    checks++;
    if (ram.ram_en !== 1'b0) begin
      failures++;
      $display("FAIL write_ram_en_width: got %b want 0", ram.ram_en);
    end
    ram.ctrl_idle = 1'b0;
    tick;
    ram.ctrl_idle = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick;
      if (req_done[0]) d0++;
      if (req_done[1]) d1++;
    end
    checks++;
    if (d0 != 1 || d1 != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL write_done: got d0=%0d d1=%0d busy=%b want 1/0/0", d0, d1, busy);
    end
  endtask

  task automatic test_read;
    int fwd_bad = 0;
    int data_bad = 0;
    int early = 0;
    int leak = 0;
    int d0 = 0;
    int d1 = 0;
    logic [UDW-1:0] exp;
    req_rdwr = 2'b10;
    req_addr = {32'h0000_2000, 32'h0};
    req_len = {11'd128, 11'd0};
    req_valid = 2'b10;
    wait_ack(1);
    req_valid = 2'b00;
    checks++;
    if (ram.ram_en !== 1'b1 || ram.ram_rdwr !== 1'b1 || owner !== 1'b1 || ram.ram_address !== 32'h2000) begin
      failures++;
      $display("FAIL read_trig: got en=%b rdwr=%b owner=%b addr=%h want 1/1/1/2000", ram.ram_en, ram.ram_rdwr, owner, ram.ram_address);
    end
    ram.ctrl_idle = 1'b0;
    tick;
    for (int i = 0; i < 64; i++) begin
      exp = UDW'(i * 3 + 5);
      ram.rd_valid = 1'b1;
      ram.rd_data = exp;
      if (i == 40) ram.ctrl_idle = 1'b1;
      #1;
      if (rd_valid_out !== 2'b10) fwd_bad++;
      if (rd_data_out !== exp) data_bad++;
      if (req_done !== 2'b00) early++;
      tick;
    end
    ram.rd_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (req_done[1]) d1++;
      if (req_done[0]) d0++;
      if (rd_valid_out[0]) leak++;
      tick;
    end
    checks++;
    if (fwd_bad != 0 || data_bad != 0 || leak != 0) begin
      failures++;
      $display("FAIL read_forward: got fwd_bad=%0d data_bad=%0d leak=%0d want 0/0/0", fwd_bad, data_bad, leak);
    end
    checks++;
    if (early != 0 || d1 != 1 || d0 != 0) begin
      failures++;
      $display("FAIL read_done: got early=%0d d1=%0d d0=%0d want 0/1/0", early, d1, d0);
    end
  endtask

  task automatic test_round_robin;
    int acks = 0;
    int dones = 0;
    int overlap = 0;
    int cd = 0;
    int order [4];
    logic in_flight = 1'b0;
    for (int k = 0; k < 4; k++) order[k] = -1;
    req_rdwr = 2'b00;
    req_len = {11'd2, 11'd2};
    req_addr = {32'h0000_0300, 32'h0000_0200};
    req_valid = 2'b11;
    for (int n = 0; n < 400 && dones < 4; n++) begin
      if (req_done != 2'b00) begin
        dones++;
        in_flight = 1'b0;
      end
      if (req_ack != 2'b00) begin
        if (in_flight) overlap++;
        in_flight = 1'b1;
        if (acks < 4) order[acks] = req_ack[1] ? 1 : 0;
        acks++;
        if (acks == 4) req_valid = 2'b00;
      end
      if (ram.ram_en) cd = 2;
      ram.ctrl_idle = (cd == 0);
      if (cd > 0) cd--;
      tick;
    end
    ram.ctrl_idle = 1'b1;
    checks++;
    if (acks != 4 || dones != 4 || overlap != 0) begin
      failures++;
      $display("FAIL rr_count: got acks=%0d dones=%0d overlap=%0d want 4/4/0", acks, dones, overlap);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] != k % 2) begin
        failures++;
        $display("FAIL rr_order%0d: got %0d want %0d", k, order[k], k % 2);
      end
    end
  endtask

  task automatic test_wr_throttle;
    int beats = 0;
    int bad = 0;
    int en_at = -1;
    int d0 = 0;
    req_rdwr = 2'b00;
    req_len = {11'd0, 11'd16};
    req_addr = {32'h0, 32'h0000_4000};
    req_valid = 2'b01;
    wait_ack(0);
    req_valid = 2'b00;
    for (int k = 0; k < 60 && en_at < 0; k++) begin
      ram.wr_buf_ready = ~k[0];
      #1;
      if (ram.wr_en) begin
        beats++;
        if (!ram.wr_buf_ready) bad++;
      end
      if (ram.ram_en) en_at = k;
      tick;
    end
    ram.wr_buf_ready = 1'b1;
    checks++;
    if (beats != 8 || bad != 0) begin
      failures++;
      $display("FAIL throttle_beats: got %0d (bad %0d) want 8 (bad 0)", beats, bad);
    end
    checks++;
    if (en_at != 15) begin
      failures++;
      $display("FAIL throttle_ram_en: got cycle %0d want 15", en_at);
    end
    ram.ctrl_idle = 1'b0;
    tick;
    ram.ctrl_idle = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick;
      if (req_done[0]) d0++;
    end
    checks++;
    if (d0 != 1) begin
      failures++;
      $display("FAIL throttle_done: got %0d want 1", d0);
    end
    ram.rd_valid = 1'b1;
    #1;
    checks++;
    if (rd_valid_out !== 2'b01) begin
      failures++;
      $display("FAIL idle_rd_forward: got %b want 01", rd_valid_out);
    end
    tick;
    ram.rd_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_rd_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    int err_at = -1;
    int dn = 0;
    logic [1:0] err_val = 2'b00;
    req_rdwr = 2'b01;
    req_len = {11'd4, 11'd4};
    req_valid2 = 2'b01;
    while (req_ack2 == 2'b00 && n < 20) begin
      tick;
      n++;
    end
    req_valid2 = 2'b00;
    checks++;
    if (req_ack2 !== 2'b01 || ram2.ram_en !== 1'b1) begin
      failures++;
      $display("FAIL tmo_grant: got ack=%b ram_en=%b want 01/1", req_ack2, ram2.ram_en);
    end
    tick;
    for (int c = 0; c < 40 && err_at < 0; c++) begin
      if (req_err2 != 2'b00) begin
        err_at = c;
        err_val = req_err2;
      end else begin
        if (req_done2 != 2'b00) dn++;
        tick;
      end
    end
    checks++;
    if (err_at != 16 || err_val !== 2'b01 || dn != 0) begin
      failures++;
      $display("FAIL tmo_err: got cycle=%0d err=%b done=%0d want 16/01/0", err_at, err_val, dn);
    end
    tick;
    checks++;
    if (busy2 !== 1'b0 || req_done2 !== 2'b00) begin
      failures++;
      $display("FAIL tmo_idle: got busy=%b done=%b want 0/00", busy2, req_done2);
    end
    req_valid2 = 2'b10;
    n = 0;
    while (req_ack2 == 2'b00 && n < 20) begin
      tick;
      n++;
    end
    req_valid2 = 2'b00;
    checks++;
    if (req_ack2 !== 2'b10) begin
      failures++;
      $display("FAIL tmo_regrant: got %b want 10", req_ack2);
    end
  endtask

  task automatic test_cal_rst;
    int seen = 0;
    cal_done = 1'b0;
    req_rdwr = 2'b00;
    req_len = {11'd128, 11'd128};
    req_valid = 2'b11;
    for (int n = 0; n < 6; n++) begin
      tick;
      if (req_ack != 2'b00 || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL cal_gate: got %0d grant cycles want 0", seen);
    end
    cal_done = 1'b1;
    req_valid = 2'b01;
    wait_ack(0);
    req_valid = 2'b00;
    tick;
    tick;
    checks++;
    if (ram.wr_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_load: got wr_en=%b busy=%b want 1/1", ram.wr_en, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ram.wr_en !== 1'b0 || busy !== 1'b0 || ram.ram_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got wr_en=%b busy=%b ram_en=%b want 0/0/0", ram.wr_en, busy, ram.ram_en);
    end
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || owner !== 1'b0 || ram.wr_en !== 1'b0 || ram.ram_rdwr !== 1'b1) begin
      failures++;
      $display("FAIL rst_after: got busy=%b owner=%b wr_en=%b rdwr=%b want 0/0/0/1", busy, owner, ram.wr_en, ram.ram_rdwr);
    end
  endtask

  initial begin
    ram.ctrl_idle = 1'b1;
    ram.wr_buf_ready = 1'b1;
    ram.rd_valid = 1'b0;
    ram.rd_data = '0;
    ram2.ctrl_idle = 1'b1;
    ram2.wr_buf_ready = 1'b1;
    ram2.rd_valid = 1'b0;
    ram2.rd_data = '0;
    test_reset;
    test_single_write;
    test_read;
    test_round_robin;
    test_wr_throttle;
    test_timeout;
    test_cal_rst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/efx_hyper_ram_native_arb.md
Name: efx_hyper_ram_native_arb

Overview:
- Two-requester round-robin arbiter and transaction sequencer in front of the HyperRAM native controller port (ram_en / ram_rdwr / address / burst_len / wr_en / rd_valid / ctrl_idle handshake).
- Lets two user masters, for example the traffic checker and a DMA engine, share one controller.
- Each granted transaction runs to completion: write data preload, trigger, controller busy, controller idle, and all read beats returned. Only then is the next request granted.

Parameters:
- USER_DBW, 128, user data width in bits; legal values 32/64/128/256.
- RAM_DBW, 32, HyperRAM DDR word width; DRATIO = USER_DBW/(RAM_DBW*2), minimum 1.
- TIMEOUT_CYC, 4096, watchdog limit in cycles for any wait state; 0 disables the watchdog.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- cal_done  in  1  controller calibration complete; no grant is issued while it is low.
- req_valid  in  2  per-requester request; held until req_ack.
- req_rdwr  in  2  per-requester direction: 1 = read, 0 = write.
- req_addr  in  64  {addr1, addr0}, 32 bits each.
- req_len  in  22  {len1, len0}, 11 bits each, in RAM words.
- req_ack  out  2  one-cycle pulse when a request is accepted.
- req_done  out  2  one-cycle pulse when a transaction completes.
- req_err  out  2  one-cycle pulse when the watchdog aborts a transaction.
- wr_pull  out  2  one-cycle write-beat strobe to the owner; the owner updates wr_data_in on the next cycle.
- wr_data_in  in  2*USER_DBW  packed write data, requester 0 in the LSBs.
- rd_data_out  out  USER_DBW  read data broadcast to both requesters.
- rd_valid_out  out  2  read beat valid, routed to the owner only.
- ram_en  out  1  transaction trigger to the controller.
- ram_rdwr  out  1  1 = read, 0 = write.
- ram_address  out  32  transaction address.
- burst_len  out  11  transaction length in RAM words.
- wr_en  out  1  write buffer load strobe.
- wr_data  out  USER_DBW  write data to the controller.
- wr_buf_ready  in  1  controller write buffer can accept a beat.
- rd_data  in  USER_DBW  controller read data.
- rd_valid  in  1  controller read beat valid.
- ctrl_idle  in  1  controller idle.
- owner  out  1  index of the current or last granted requester.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state = IDLE, rr_ptr = 0, owner = 0. All strobes, ram_en, wr_en, rd_valid_out and busy are 0. ram_rdwr = 1. ram_address, burst_len and the beat counters are 0.
- Beat count: beats = max(1, len >> log2(DRATIO)), computed when the request is latched. A len of 0 is treated as 1 beat.
- Arbitration happens in IDLE only, and only when cal_done = 1.
  - The requester at rr_ptr wins if it is valid; otherwise the other requester wins.
  - On a grant, addr, len, rdwr and owner are latched and req_ack is pulsed for that requester.
  - rr_ptr = ~winner, updated in the same cycle as the grant.
- States:
  - IDLE: grant as above. A write goes to LOAD; a read goes to TRIG.
  - LOAD: wr_en = wr_pull[owner] = wr_buf_ready. wr_data = the owner's slice of wr_data_in. Each beat increments the write count. When the count reaches beats, go to TRIG. No wr_en is asserted once the count equals beats.
  - TRIG: ram_en = 1 for exactly one cycle; ram_rdwr reflects the latched direction. Then go to WBUSY.
  - WBUSY: wait for ctrl_idle = 0, then go to WIDLE.
  - WIDLE: wait for ctrl_idle = 1. For a read, the read count must also have reached beats. Then go to DONE.
  - DONE: pulse req_done[owner], then go to IDLE.
- rd_valid is accepted in any state. rd_valid_out[owner] = rd_valid (combinational). Read beats are counted only while a read is owned. A rd_valid that arrives while IDLE is forwarded to the last owner and is not counted.
- The read beat counter saturates at beats; extra beats are still forwarded.
- Watchdog: a counter clears on every state change and increments in LOAD, WBUSY and WIDLE. When it reaches TIMEOUT_CYC: pulse req_err[owner], do not pulse done, and return to IDLE.
- cal_done falling while a transaction is active has no effect; the transaction runs to completion or timeout.
- Both requesters valid on every grant: grants alternate 0, 1, 0, 1, ...
- Reset asserted mid-transaction: everything returns to reset values immediately. Strobes drop asynchronously.

Decomposition:
- Shared package efx_hbram_pkg holds:
  - state encodings IDLE=0, LOAD=1, TRIG=2, WBUSY=3, WIDLE=4, DONE=5;
  - the DRATIO function;
  - the default TIMEOUT_CYC.
- Natural sub-module: efx_rr_arb2, the 2-way round-robin pick plus pointer register. The sequencer stays in the top module.

Test Plan:
- Single write, USER_DBW=128, len=128 (DRATIO=2), wr_buf_ready=1 → 64 wr_en beats, then a 1-cycle ram_en with ram_rdwr=0. After ctrl_idle goes 0 then 1, req_done[0] pulses once.
- Read from requester 1, len=128: the controller returns 64 rd_valid beats, and ctrl_idle goes high after beat 40 → req_done[1] pulses only after beat 64, and rd_valid_out[0] stays 0 throughout.
- Both requesters hold req_valid for 4 transactions → ack order is 0, 1, 0, 1. A new grant never starts before the prior req_done.
- wr_buf_ready toggles 1,0,1,0 during LOAD with len=16 → exactly 8 wr_en beats, each coinciding with wr_buf_ready=1. ram_en fires one cycle after the last beat.
- TIMEOUT_CYC=16 and ctrl_idle held high after TRIG → req_err pulses at WBUSY cycle 16, req_done stays 0, and the state returns to IDLE. The next request is granted.
- cal_done=0 with req_valid=2'b11 → no req_ack. Asserting rst during LOAD → wr_en, busy and ram_en go 0 immediately, and the state is IDLE after rst deasserts.
